// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage: ALU op classes, ALU controls and funct fields.
package exec_pkg;
    localparam int XLEN_DEFAULT = 64;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    typedef enum logic [3:0] {
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND
    } alu_ctrl_t;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;
endpackage

// File: rtl/exec_alu.sv
// Combinational ALU: one result per alu_ctrl_t, plus a zero flag used for branch compares.
module exec_alu
    import exec_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  alu_ctrl_t         ctrl,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic [XLEN-1:0]   result,
    output logic              zero
);
    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0] shamt;
    assign shamt = b[SHW-1:0];

    always_comb begin
        result = '0;
        case (ctrl)
            ADD:  result = a + b;
            SUB:  result = a - b;
            SLL:  result = a << shamt;
            SLT:  result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            SLTU: result = {{(XLEN-1){1'b0}}, a < b};
            XOR:  result = a ^ b;
            SRL:  result = a >> shamt;
            SRA:  result = $signed(a) >>> shamt;
            OR:   result = a | b;
            AND:  result = a & b;
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);
endmodule

// File: rtl/execute_stage.sv
// EX stage: ALU, branch resolution with wrong-path squash, and the EX/MEM pipeline register.
module execute_stage
    import exec_pkg::*;
#(
    parameter int XLEN         = XLEN_DEFAULT,
    parameter int SHADOW_SLOTS = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic              i_stall,
    input  logic [31:0]       i_instruction,
    input  logic [XLEN-1:0]   i_pc,
    input  logic [XLEN-1:0]   i_rs1_value,
    input  logic [XLEN-1:0]   i_rs2_value,
    input  logic [XLEN-1:0]   i_immediate,
    input  logic [1:0]        i_alu_op,
    input  logic              i_alu_src,
    input  logic              i_branch,
    input  logic              i_mem_write,
    input  logic              i_mem_read,
    input  logic              i_mem_to_reg,
    input  logic              i_reg_write,
    output logic              o_valid,
    output logic [XLEN-1:0]   o_alu_result,
    output logic [XLEN-1:0]   o_store_data,
    output logic [4:0]        o_rd_index,
    output logic              o_mem_write,
    output logic              o_mem_read,
    output logic              o_mem_to_reg,
    output logic              o_reg_write,
    output logic              o_branch_taken,
    output logic [XLEN-1:0]   o_branch_target,
    output logic              o_illegal
);
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_res;
    logic            alu_zero;
    alu_ctrl_t       ctrl;
    logic            rtype_bad;
    logic            alu_bad;
    logic            br_bad;
    logic            br_cond;
    logic            accept;
    logic            keep_ctrl;
    logic [1:0]      squash_cnt;

    assign funct3 = i_instruction[14:12];
    assign funct7 = i_instruction[31:25];
    assign op_b   = i_alu_src ? i_immediate : i_rs2_value;

    // Opcode and rs fields are resolved upstream; only funct/rd matter here.
    logic unused_instr;
    assign unused_instr = ^{i_instruction[24:15], i_instruction[6:0]};

    always_comb begin
        ctrl      = ADD;
        rtype_bad = 1'b0;
        case (i_alu_op)
            ALUOP_ADD: ctrl = ADD;
            ALUOP_SUB: ctrl = SUB;
            ALUOP_RTYPE: begin
                case (funct3)
                    F3_ADD_SUB: begin
                        ctrl      = (funct7 == F7_ALT) ? SUB : ADD;
                        rtype_bad = (funct7 != F7_BASE) && (funct7 != F7_ALT);
                    end
                    F3_SRL_SRA: begin
                        ctrl      = (funct7 == F7_ALT) ? SRA : SRL;
                        rtype_bad = (funct7 != F7_BASE) && (funct7 != F7_ALT);
                    end
                    default: begin
                        case (funct3)
                            F3_SLL:  ctrl = SLL;
                            F3_SLT:  ctrl = SLT;
                            F3_SLTU: ctrl = SLTU;
                            F3_XOR:  ctrl = XOR;
                            F3_OR:   ctrl = OR;
                            default: ctrl = AND;
                        endcase
                        rtype_bad = (funct7 != F7_BASE);
                    end
                endcase
            end
            default: ctrl = ADD;
        endcase
        // Branches always compare A against B through the subtractor's zero flag.
        if (i_branch) ctrl = SUB;
    end

    exec_alu #(.XLEN(XLEN)) u_alu (
        .ctrl   (ctrl),
        .a      (i_rs1_value),
        .b      (op_b),
        .result (alu_res),
        .zero   (alu_zero)
    );

    assign alu_bad   = (i_alu_op == 2'b11) || ((i_alu_op == ALUOP_RTYPE) && rtype_bad);
    assign br_bad    = i_branch && (funct3 != F3_BEQ) && (funct3 != F3_BNE);
    assign br_cond   = i_branch && ((funct3 == F3_BEQ) ? alu_zero :
                                    (funct3 == F3_BNE) ? !alu_zero : 1'b0);
    assign accept    = i_valid && !i_stall && (squash_cnt == 2'd0);
    assign keep_ctrl = accept && (i_alu_op != 2'b11);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_valid         <= 1'b0;
            o_alu_result    <= '0;
            o_store_data    <= '0;
            o_rd_index      <= '0;
            o_mem_write     <= 1'b0;
            o_mem_read      <= 1'b0;
            o_mem_to_reg    <= 1'b0;
            o_reg_write     <= 1'b0;
            o_branch_taken  <= 1'b0;
            o_branch_target <= '0;
            o_illegal       <= 1'b0;
            squash_cnt      <= 2'd0;
        end else if (!i_stall) begin
            o_valid        <= accept;
            o_mem_write    <= keep_ctrl && i_mem_write;
            o_mem_read     <= keep_ctrl && i_mem_read;
            o_mem_to_reg   <= keep_ctrl && i_mem_to_reg;
            o_reg_write    <= keep_ctrl && i_reg_write && !i_branch;
            o_branch_taken <= accept && br_cond;
            o_illegal      <= accept && (alu_bad || br_bad);
            // Only real instructions consume a shadow slot; bubbles leave it alone.
            if (i_valid && squash_cnt != 2'd0)
                squash_cnt <= squash_cnt - 2'd1;
            if (accept) begin
                o_alu_result    <= alu_bad ? '0 : alu_res;
                o_store_data    <= i_rs2_value;
                o_rd_index      <= i_instruction[11:7];
                o_branch_target <= i_pc + i_immediate;
                if (br_cond)
                    squash_cnt <= 2'(SHADOW_SLOTS);
            end
        end
    end
endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Consumer end of the ID/EX pipeline interface. Takes the decode stage's registered operands, immediate, PC, instruction and control bits (alu_op, alu_src, branch, mem_*, reg_write).
- Computes the ALU result and resolves branches.
- Registers everything into the EX/MEM pipeline register for the memory stage.
- Drives a registered branch redirect back to fetch, and squashes the wrong-path instructions already in flight.

Parameters:
- XLEN, 64, datapath width
- SHADOW_SLOTS, 2, number of valid instructions squashed after a taken branch (range 0-3)

Ports:
- i_clk  in  1  clock, all state updates on rising edge
- i_rst_n  in  1  synchronous active-low reset
- i_valid  in  1  ID/EX entry holds a real instruction
- i_stall  in  1  downstream stall; hold all state, do not consume the input
- i_instruction  in  32  raw instruction (funct3 [14:12], funct7 [31:25], rd [11:7])
- i_pc  in  XLEN  instruction PC
- i_rs1_value  in  XLEN  operand A
- i_rs2_value  in  XLEN  operand B / store data
- i_immediate  in  XLEN  sign-extended immediate
- i_alu_op  in  2  00 add, 01 sub/compare, 10 R-type by funct, 11 reserved
- i_alu_src  in  1  1 selects immediate as operand B
- i_branch, i_mem_write, i_mem_read, i_mem_to_reg, i_reg_write  in  1 each  control bits
- o_valid  out  1  EX/MEM entry valid
- o_alu_result  out  XLEN  registered ALU result
- o_store_data  out  XLEN  registered rs2 value
- o_rd_index  out  5  registered rd
- o_mem_write, o_mem_read, o_mem_to_reg, o_reg_write  out  1 each  registered control bits; forced 0 when entry invalid
- o_branch_taken  out  1  one-cycle redirect pulse
- o_branch_target  out  XLEN  i_pc + i_immediate, valid with o_branch_taken
- o_illegal  out  1  registered; alu_op 11 or unsupported R-type funct on a valid instruction

Behaviour:
- Reset (i_rst_n=0 at a rising edge):
  - all outputs 0;
  - squash counter 0;
  - reset wins over stall and valid.
- Latency: 1 cycle. An input accepted at edge N appears on the outputs after edge N.
- Accept condition: i_valid & ~i_stall & (squash_cnt==0).
- Stall (i_stall=1):
  - every output and squash_cnt hold their values;
  - o_branch_taken also holds; fetch qualifies it with stall.
- Squash (i_valid & ~i_stall & squash_cnt>0):
  - squash_cnt decrements;
  - o_valid=0, all control outputs 0, o_branch_taken=0.
- Bubble (i_valid=0, not stalled):
  - o_valid=0, control outputs 0, o_branch_taken=0;
  - squash_cnt unchanged; only valid instructions count as shadow slots.
- Operand B: i_alu_src ? i_immediate : i_rs2_value.
- ALU decode:
  - alu_op 00: add.
  - alu_op 01: sub.
  - alu_op 10, by funct3/funct7[5]:
    - 000/0 add, 000/1 sub
    - 001 sll
    - 010 slt (signed)
    - 011 sltu
    - 100 xor
    - 101/0 srl, 101/1 sra
    - 110 or
    - 111 and
  - Shift amount is B[5:0]. Any other funct7 gives result 0 and o_illegal=1.
  - alu_op 11: result 0, o_illegal=1, reg_write/mem bits forced 0.
- Arithmetic wraps modulo 2^XLEN; no overflow flag.
- Branch (accepted & i_branch):
  - funct3 000 (beq) taken when A==B; 001 (bne) taken when A!=B; other funct3 not taken and o_illegal=1.
  - When taken:
    - o_branch_taken=1 for one cycle;
    - o_branch_target = i_pc+i_immediate (mod 2^XLEN);
    - squash_cnt loads SHADOW_SLOTS.
- Branch entries are written to EX/MEM with o_valid=1 and reg_write=0, so they retire for counting.
- A branch arriving inside a shadow is squashed and cannot redirect.

Decomposition:
- Shared package exec_pkg:
  - alu_op encodings (ALUOP_ADD, ALUOP_SUB, ALUOP_RTYPE);
  - alu_ctrl_t enum (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND);
  - funct3 constants including F3_BEQ, F3_BNE;
  - the XLEN default.
- One combinational sub-module, exec_alu: alu_ctrl_t, A, B in; result and zero flag out.
- execute_stage holds the control decode, the branch logic, the squash counter and the pipeline register.

Test Plan:
- R-type add: A=5, B=7, alu_op=10, funct3=000, funct7=0 -> next cycle o_alu_result=12, o_reg_write=1, o_valid=1.
- Load: A=0x1000, imm=-8, alu_src=1, alu_op=00, mem_read=1 -> o_alu_result=0xFF8, o_mem_read=1, o_mem_to_reg=1.
- sra: A=0x8000000000000000, B=4, funct3=101, funct7[5]=1 -> 0xF800000000000000.
- Taken beq at pc=0x40, imm=0x10, A=B=3:
  - o_branch_taken=1 and o_branch_target=0x50 for exactly one cycle;
  - the next 2 valid inputs leave o_valid=0;
  - the 3rd valid input is accepted.
- Stall mid-shadow: after a taken branch, hold i_stall=1 for 3 cycles -> outputs frozen, squash_cnt stays 2; a bubble during the shadow does not decrement it.
- Reset while squash_cnt=1 and i_stall=1 -> all outputs 0 next cycle; the following valid input is accepted immediately.
